voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Next-generation polyphony dispatcher. Maps MIDI note on/off events onto VOICES synth pipelines.
//  Adds the following over the current dispatcher: valid/ready input handshake, same-note retrigger,
//  oldest-voice stealing when all voices are busy, and a velocity-0 ON treated as OFF.
//  Sits between the MIDI decoder and the per-voice oscillator/envelope pipelines.
// PARAMETERS
//  VOICES  8   number of voice pipelines (>=2)
//  NOTE_W  7   note number width
//  VEL_W   7   velocity width
//  CNT_W   16  steal counter width
// PORTS
//  clk             in   1              system clock
//  reset_n         in   1              asynchronous, active-low reset
//  ev_valid        in   1              event present
//  ev_ready        out  1              allocator can accept event
//  ev_kind         in   note_en_t      ON / OFF (conFFTi)
//  ev_note         in   NOTE_W         note number
//  ev_velocity     in   VEL_W          velocity
//  sustain_in      in   1              sustain pedal level (only with SUSTAIN_PEDAL_EN)
//  voice_en        out  VOICES         voice gate per pipeline
//  voice_note      out  VOICES*NOTE_W  note per voice
//  voice_velocity  out  VOICES*VEL_W   velocity per voice
//  voice_retrig    out  VOICES         1-cycle pulse when a voice is (re)assigned
//  steal_count     out  CNT_W          saturating count of steals
// BEHAVIOUR
//  Reset: all outputs 0; ev_ready=1; FSM=IDLE; all ranks reset (voice i rank=i).
//  Event accepted on posedge clk when ev_valid&&ev_ready. Results are visible the next cycle (1-cycle latency).
//  ON with velocity 0 is processed as OFF.
//  ON, note already held in voice v: velocity updated, voice_retrig[v] pulses, v becomes youngest. No second voice.
//  ON, free voice exists: lowest-index free voice gets en=1, note, velocity, retrig pulse; becomes youngest.
//  ON, no free voice: steal. Cycle 1 accepts the event; voice_en[o]=0 for the oldest voice o; FSM IDLE->STEAL;
//    ev_ready=0. Cycle 2 assigns o as a free voice and increments steal_count (saturates at all-ones); STEAL->IDLE.
//    The guaranteed 1-cycle gate-low lets the envelope release.
//  OFF matching voice v: en, note and velocity are cleared to 0. OFF with no match is ignored.
//  Age: LRU rank 0..VOICES-1 per voice, 0=youngest. When v is touched, ranks below old rank[v] get +1, and rank[v]=0.
//    Ranks stay a permutation at all times.
//  ev_ready is 0 only in STEAL.
//  reset_n asserted mid-steal returns to the reset state and drops the pending assignment.
//  voice_retrig is never high for more than one cycle per event.
// CONFIGURATION
//  SUSTAIN_PEDAL_EN defined:
//    - sustain_in port exists.
//    - OFF while sustain_in=1 marks the voice sustained and keeps en=1.
//    - A sustain_in 1->0 transition (registered edge) clears all sustained voices in that cycle.
//    - ON to a sustained note clears its sustained flag and retriggers.
//    - If the same cycle carries an event and a pedal release, the event result wins for its voice.
//  SUSTAIN_PEDAL_EN undefined: no sustain_in port; OFF always clears immediately.
// STRUCTURE
//  Package conFFTi: reuse note_en_t; add alloc_state_t {IDLE, STEAL} and voice_t {en, sustained, note, velocity}.
//  Sub-module voice_age_tracker (#VOICES): touch_en, touch_idx in; rank array and oldest_idx out.
//  Existing search module used for free-voice and note-match lookup.
// TESTING
//  1. Reset; ON 60/100 -> next cycle voice_en=0x01, note[0]=60, vel[0]=100, retrig[0] pulses once.
//  2. ON 60/100, then ON 60/40 -> still only voice 0 enabled, vel[0]=40, second retrig pulse; steal_count=0.
//  3. ON 60..67 (VOICES=8), then ON 72 -> ev_ready=0 for 1 cycle; voice_en[0]=0 for 1 cycle;
//     then note[0]=72, en=0xFF, steal_count=1.
//  4. ON 64/90 then ON 64/0 -> voice cleared (treated as OFF); OFF 50 unmatched -> no output change.
//  5. SUSTAIN_PEDAL_EN: sustain=1, ON 60, OFF 60 -> en stays 1; sustain->0 -> en[0]=0 next cycle.
//  6. Assert reset_n low during STEAL -> all outputs 0, ev_ready=1; after release, ON 48 lands in voice 0.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// Shared types for the polyphony dispatcher: event kind, allocator FSM state
// and the per-voice record held by voice_allocator.
package voice_allocator_pkg;

    localparam int NOTE_W_DEF = 7;
    localparam int VEL_W_DEF  = 7;

    typedef enum logic {
        NOTE_OFF = 1'b0,
        NOTE_ON  = 1'b1
    } note_en_t;

    typedef enum logic {
        IDLE  = 1'b0,
        STEAL = 1'b1
    } alloc_state_t;

    typedef struct packed {
        logic                  en;
        logic                  sustained;
        logic [NOTE_W_DEF-1:0] note;
        logic [VEL_W_DEF-1:0]  velocity;
    } voice_t;

    // A note-on carrying velocity 0 is a note-off in MIDI running-status practice.
    function automatic logic is_note_on(input note_en_t kind, input logic [VEL_W_DEF-1:0] vel);
        return (kind == NOTE_ON) && (vel != {VEL_W_DEF{1'b0}});
    endfunction

endpackage

// File: rtl/voice_allocator_age_tracker.sv
// LRU age tracker: one rank per voice, 0 = most recently touched.
// Touching voice v ages every voice younger than v by one and makes v youngest,
// so the ranks always remain a permutation of 0..VOICES-1.
module voice_age_tracker #(
    parameter  int VOICES = 8,
    localparam int IDX_W  = $clog2(VOICES)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    touch_en,
    input  logic [IDX_W-1:0]        touch_idx,
    output logic [VOICES*IDX_W-1:0] rank,
    output logic [IDX_W-1:0]        oldest_idx
);

    logic [IDX_W-1:0] rank_q [VOICES];
    logic [IDX_W-1:0] rank_d [VOICES];
    logic [IDX_W-1:0] touched_rank_s;

    // Next ranks: touched voice goes to 0, voices younger than it age by one.
    always_comb begin
        touched_rank_s = rank_q[touch_idx];
        for (int i = 0; i < VOICES; i++) begin
            rank_d[i] = rank_q[i];
            if (touch_en) begin
                if (IDX_W'(i) == touch_idx) begin
                    rank_d[i] = '0;
                end else if (rank_q[i] < touched_rank_s) begin
                    rank_d[i] = rank_q[i] + IDX_W'(1);
                end else begin
                    rank_d[i] = rank_q[i];
                end
            end else begin
                rank_d[i] = rank_q[i];
            end
        end
    end

    // Rank registers; reset leaves voice i at rank i.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < VOICES; i++) begin
                rank_q[i] <= IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                rank_q[i] <= rank_d[i];
            end
        end
    end

    // Flatten ranks and locate the voice holding the highest rank.
    always_comb begin
        rank       = '0;
        oldest_idx = '0;
        for (int i = 0; i < VOICES; i++) begin
            rank[i*IDX_W +: IDX_W] = rank_q[i];
            if (rank_q[i] == IDX_W'(VOICES - 1)) begin
                oldest_idx = IDX_W'(i);
            end else begin
                oldest_idx = oldest_idx;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony dispatcher: maps note on/off events onto VOICES synth pipelines
// with same-note retrigger, lowest-free-voice allocation and oldest-voice
// stealing (two cycles: gate low, then reassign).
// Optional feature macro: SUSTAIN_PEDAL_EN (adds sustain_in and pedal hold).
// Note and velocity widths follow the package record (voice_t).
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int VOICES = 8,
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int VEL_W  = VEL_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ev_valid,
    output logic                     ev_ready,
    input  note_en_t                 ev_kind,
    input  logic [NOTE_W-1:0]        ev_note,
    input  logic [VEL_W-1:0]         ev_velocity,
`ifdef SUSTAIN_PEDAL_EN
    input  logic                     sustain_in,
`endif
    output logic [VOICES-1:0]        voice_en,
    output logic [VOICES*NOTE_W-1:0] voice_note,
    output logic [VOICES*VEL_W-1:0]  voice_velocity,
    output logic [VOICES-1:0]        voice_retrig,
    output logic [CNT_W-1:0]         steal_count
);

    localparam int IDX_W = $clog2(VOICES);

    alloc_state_t         state_q, state_d;
    voice_t               voices_q [VOICES];
    voice_t               voices_d [VOICES];
    logic [NOTE_W-1:0]    pend_note_q, pend_note_d;
    logic [VEL_W-1:0]     pend_vel_q, pend_vel_d;
    logic [IDX_W-1:0]     steal_idx_q, steal_idx_d;
    logic [VOICES-1:0]    retrig_q, retrig_d;
    logic [CNT_W-1:0]     steal_count_q, steal_count_d;
`ifdef SUSTAIN_PEDAL_EN
    logic                 sus_prev_q, sus_prev_d;
    logic                 pedal_release_s;
`endif

    logic                 accept_s;
    logic                 is_on_s;
    logic                 match_hit_s;
    logic [IDX_W-1:0]     match_idx_s;
    logic                 free_hit_s;
    logic [IDX_W-1:0]     free_idx_s;
    logic                 touch_en_s;
    logic [IDX_W-1:0]     touch_idx_s;
    logic [IDX_W-1:0]     oldest_idx_s;
    logic [VOICES*IDX_W-1:0] rank_s;

    voice_age_tracker #(
        .VOICES (VOICES)
    ) u_age (
        .clk        (clk),
        .reset_n    (reset_n),
        .touch_en   (touch_en_s),
        .touch_idx  (touch_idx_s),
        .rank       (rank_s),
        .oldest_idx (oldest_idx_s)
    );

    assign ev_ready = (state_q == IDLE);
    assign accept_s = ev_valid && ev_ready;
    assign is_on_s  = is_note_on(ev_kind, ev_velocity);

    // Lookup of the lowest-index voice holding ev_note and the lowest-index free voice.
    always_comb begin
        match_hit_s = 1'b0;
        match_idx_s = '0;
        free_hit_s  = 1'b0;
        free_idx_s  = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (voices_q[i].en && (voices_q[i].note == ev_note)) begin
                match_hit_s = 1'b1;
                match_idx_s = IDX_W'(i);
            end else begin
                match_hit_s = match_hit_s;
                match_idx_s = match_idx_s;
            end
            if (!voices_q[i].en) begin
                free_hit_s = 1'b1;
                free_idx_s = IDX_W'(i);
            end else begin
                free_hit_s = free_hit_s;
                free_idx_s = free_idx_s;
            end
        end
    end

    // Next-state: pedal release first, then the event or steal completion overrides its voice.
    always_comb begin
        state_d       = state_q;
        pend_note_d   = pend_note_q;
        pend_vel_d    = pend_vel_q;
        steal_idx_d   = steal_idx_q;
        steal_count_d = steal_count_q;
        retrig_d      = '0;
        touch_en_s    = 1'b0;
        touch_idx_s   = '0;
        for (int i = 0; i < VOICES; i++) begin
            voices_d[i] = voices_q[i];
        end

`ifdef SUSTAIN_PEDAL_EN
        sus_prev_d      = sustain_in;
        pedal_release_s = sus_prev_q && !sustain_in;
        for (int i = 0; i < VOICES; i++) begin
            if (pedal_release_s && voices_q[i].sustained) begin
                voices_d[i] = '0;
            end else begin
                voices_d[i] = voices_d[i];
            end
        end
`endif

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if (is_on_s) begin
                        if (match_hit_s) begin
                            voices_d[match_idx_s] = '{en: 1'b1, sustained: 1'b0,
                                                      note: ev_note, velocity: ev_velocity};
                            retrig_d[match_idx_s] = 1'b1;
                            touch_en_s            = 1'b1;
                            touch_idx_s           = match_idx_s;
                        end else if (free_hit_s) begin
                            voices_d[free_idx_s] = '{en: 1'b1, sustained: 1'b0,
                                                     note: ev_note, velocity: ev_velocity};
                            retrig_d[free_idx_s] = 1'b1;
                            touch_en_s           = 1'b1;
                            touch_idx_s          = free_idx_s;
                        end else begin
                            // Gate the victim low for one cycle so its envelope releases.
                            voices_d[oldest_idx_s].en        = 1'b0;
                            voices_d[oldest_idx_s].sustained = 1'b0;
                            steal_idx_d = oldest_idx_s;
                            pend_note_d = ev_note;
                            pend_vel_d  = ev_velocity;
                            state_d     = STEAL;
                        end
                    end else begin
                        if (match_hit_s) begin
`ifdef SUSTAIN_PEDAL_EN
                            if (sustain_in) begin
                                voices_d[match_idx_s].en        = 1'b1;
                                voices_d[match_idx_s].sustained = 1'b1;
                            end else begin
                                voices_d[match_idx_s] = '0;
                            end
`else
                            voices_d[match_idx_s] = '0;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            STEAL: begin
                voices_d[steal_idx_q] = '{en: 1'b1, sustained: 1'b0,
                                          note: pend_note_q, velocity: pend_vel_q};
                retrig_d[steal_idx_q] = 1'b1;
                touch_en_s            = 1'b1;
                touch_idx_s           = steal_idx_q;
                if (steal_count_q != {CNT_W{1'b1}}) begin
                    steal_count_d = steal_count_q + CNT_W'(1);
                end else begin
                    steal_count_d = steal_count_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, voice table, pending steal and output pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pend_note_q   <= '0;
            pend_vel_q    <= '0;
            steal_idx_q   <= '0;
            retrig_q      <= '0;
            steal_count_q <= '0;
            for (int i = 0; i < VOICES; i++) begin
                voices_q[i] <= '0;
            end
`ifdef SUSTAIN_PEDAL_EN
            sus_prev_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pend_note_q   <= pend_note_d;
            pend_vel_q    <= pend_vel_d;
            steal_idx_q   <= steal_idx_d;
            retrig_q      <= retrig_d;
            steal_count_q <= steal_count_d;
            for (int i = 0; i < VOICES; i++) begin
                voices_q[i] <= voices_d[i];
            end
`ifdef SUSTAIN_PEDAL_EN
            sus_prev_q    <= sus_prev_d;
`endif
        end
    end

    // Flatten the registered voice table onto the output buses.
    always_comb begin
        voice_en       = '0;
        voice_note     = '0;
        voice_velocity = '0;
        for (int i = 0; i < VOICES; i++) begin
            voice_en[i]                      = voices_q[i].en;
            voice_note[i*NOTE_W +: NOTE_W]   = voices_q[i].note;
            voice_velocity[i*VEL_W +: VEL_W] = voices_q[i].velocity;
        end
    end

    assign voice_retrig = retrig_q;
    assign steal_count  = steal_count_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: the stimulus thread pushes the
// hand-computed expected output state for every clock; a monitor pops and
// compares on each falling edge.
module tb_voice_allocator;
    import voice_allocator_pkg::*;

    localparam int V  = 8;
    localparam int NW = 7;
    localparam int VW = 7;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            ev_valid = 1'b0;
    logic            ev_ready;
    note_en_t        ev_kind = NOTE_OFF;
    logic [NW-1:0]   ev_note = '0;
    logic [VW-1:0]   ev_velocity = '0;
`ifdef SUSTAIN_PEDAL_EN
    logic            sustain_in = 1'b0;
`endif
    logic [V-1:0]    voice_en;
    logic [V*NW-1:0] voice_note;
    logic [V*VW-1:0] voice_velocity;
    logic [V-1:0]    voice_retrig;
    logic [CW-1:0]   steal_count;

    voice_allocator #(.VOICES(V), .NOTE_W(NW), .VEL_W(VW), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_kind        (ev_kind),
        .ev_note        (ev_note),
        .ev_velocity    (ev_velocity),
`ifdef SUSTAIN_PEDAL_EN
        .sustain_in     (sustain_in),
`endif
        .voice_en       (voice_en),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_retrig   (voice_retrig),
        .steal_count    (steal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [V-1:0]    en;
        logic [V*NW-1:0] note;
        logic [V*VW-1:0] vel;
        logic [V-1:0]    retrig;
        logic [CW-1:0]   cnt;
        logic            ready;
        string           tag;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Hand-maintained expected output state.
    logic [V-1:0]  e_en;
    logic [NW-1:0] e_note [V];
    logic [VW-1:0] e_vel [V];
    logic [V-1:0]  e_retrig;
    logic [CW-1:0] e_cnt;
    logic          e_ready;

    task automatic check(input string name, input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s [%s]: got %h, expected %h", name, tag, act, exp);
        end
    endtask

    task automatic model_reset();
        e_en = '0;
        e_retrig = '0;
        e_cnt = '0;
        e_ready = 1'b1;
        for (int i = 0; i < V; i++) begin
            e_note[i] = '0;
            e_vel[i] = '0;
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.en = e_en;
        e.retrig = e_retrig;
        e.cnt = e_cnt;
        e.ready = e_ready;
        e.tag = tag;
        e.note = '0;
        e.vel = '0;
        for (int i = 0; i < V; i++) begin
            e.note[i*NW +: NW] = e_note[i];
            e.vel[i*VW +: VW] = e_vel[i];
        end
        sb_q.push_back(e);
        e_retrig = '0;
    endtask

    // Drive one clock of input, then queue the state expected after that edge.
    task automatic cycle(input logic v, input note_en_t k, input logic [NW-1:0] n,
                         input logic [VW-1:0] vel, input string tag);
        ev_valid = v;
        ev_kind = k;
        ev_note = n;
        ev_velocity = vel;
        @(posedge clk);
        push_exp(tag);
        #1;
        ev_valid = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("voice_en", e.tag, 64'(voice_en), 64'(e.en));
            check("voice_note", e.tag, 64'(voice_note), 64'(e.note));
            check("voice_velocity", e.tag, 64'(voice_velocity), 64'(e.vel));
            check("voice_retrig", e.tag, 64'(voice_retrig), 64'(e.retrig));
            check("steal_count", e.tag, 64'(steal_count), 64'(e.cnt));
            check("ev_ready", e.tag, 64'(ev_ready), 64'(e.ready));
        end
    end

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #1 push_exp("reset");
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // First note lands in voice 0, retrig pulses once.
        e_en[0] = 1'b1; e_note[0] = 7'd60; e_vel[0] = 7'd100; e_retrig[0] = 1'b1;
        cycle(1'b1, NOTE_ON, 7'd60, 7'd100, "on60");
        cycle(1'b0, NOTE_OFF, 7'd0, 7'd0, "on60_idle");

        // Same note retriggers in place with the new velocity.
        e_vel[0] = 7'd40; e_retrig[0] = 1'b1;
        cycle(1'b1, NOTE_ON, 7'd60, 7'd40, "retrig60");
        cycle(1'b0, NOTE_OFF, 7'd0, 7'd0, "retrig_idle");

        // Fill voices 1..7.
        for (int n = 61; n <= 67; n++) begin
            e_en[n-60] = 1'b1; e_note[n-60] = NW'(n); e_vel[n-60] = VW'(20 + n - 60);
            e_retrig[n-60] = 1'b1;
            cycle(1'b1, NOTE_ON, NW'(n), VW'(20 + n - 60), "fill");
        end

        // All busy: voice 0 is oldest; gate low, then reassigned.
        e_en[0] = 1'b0; e_ready = 1'b0;
        cycle(1'b1, NOTE_ON, 7'd72, 7'd50, "steal_gate");
        e_en[0] = 1'b1; e_note[0] = 7'd72; e_vel[0] = 7'd50; e_retrig[0] = 1'b1;
        e_cnt = 16'd1; e_ready = 1'b1;
        cycle(1'b0, NOTE_OFF, 7'd0, 7'd0, "steal_assign");
        cycle(1'b0, NOTE_OFF, 7'd0, 7'd0, "steal_idle");

        // OFF clears, velocity-0 ON clears, unmatched OFF ignored.
        e_en[1] = 1'b0; e_note[1] = '0; e_vel[1] = '0;
        cycle(1'b1, NOTE_OFF, 7'd61, 7'd5, "off61");
        e_vel[4] = 7'd90; e_retrig[4] = 1'b1;
        cycle(1'b1, NOTE_ON, 7'd64, 7'd90, "on64_90");
        e_en[4] = 1'b0; e_note[4] = '0; e_vel[4] = '0;
        cycle(1'b1, NOTE_ON, 7'd64, 7'd0, "on64_vel0");
        cycle(1'b1, NOTE_OFF, 7'd50, 7'd9, "off50_nomatch");

        // Lowest free index wins (voices 1 and 4 free).
        e_en[1] = 1'b1; e_note[1] = 7'd80; e_vel[1] = 7'd10; e_retrig[1] = 1'b1;
        cycle(1'b1, NOTE_ON, 7'd80, 7'd10, "on80_v1");
        e_en[4] = 1'b1; e_note[4] = 7'd81; e_vel[4] = 7'd11; e_retrig[4] = 1'b1;
        cycle(1'b1, NOTE_ON, 7'd81, 7'd11, "on81_v4");

        // Oldest is now voice 2; start a steal and reset in the middle of it.
        e_en[2] = 1'b0; e_ready = 1'b0;
        cycle(1'b1, NOTE_ON, 7'd90, 7'd12, "steal2_gate");
        @(negedge clk);
        #1 reset_n = 1'b0;
        model_reset();
        push_exp("reset_mid_steal");
        @(posedge clk);
        #1 reset_n = 1'b1;
        cycle(1'b0, NOTE_OFF, 7'd0, 7'd0, "post_reset_idle");
        e_en[0] = 1'b1; e_note[0] = 7'd48; e_vel[0] = 7'd30; e_retrig[0] = 1'b1;
        cycle(1'b1, NOTE_ON, 7'd48, 7'd30, "on48_after_reset");

`ifdef SUSTAIN_PEDAL_EN
        // Pedal holds released notes; ON to a held note retriggers; release clears.
        sustain_in = 1'b1;
        cycle(1'b0, NOTE_OFF, 7'd0, 7'd0, "pedal_down");
        cycle(1'b1, NOTE_OFF, 7'd48, 7'd0, "off48_held");
        e_vel[0] = 7'd70; e_retrig[0] = 1'b1;
        cycle(1'b1, NOTE_ON, 7'd48, 7'd70, "on48_sustained");
        cycle(1'b1, NOTE_OFF, 7'd48, 7'd0, "off48_held2");
        sustain_in = 1'b0;
        e_en[0] = 1'b0; e_note[0] = '0; e_vel[0] = '0;
        cycle(1'b0, NOTE_OFF, 7'd0, 7'd0, "pedal_release");
`endif

        cycle(1'b0, NOTE_OFF, 7'd0, 7'd0, "final_idle");

        // Drain: every queued expectation must have been consumed.
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
